// File: rtl/mm3x3_sequencer.sv
// Sequencer for a 3x3 matrix multiply: walks C row-major and, for each element,
// issues a clear, three MAC steps, ACC_LAT drain cycles and one write strobe.
module mm3x3_sequencer #(
  parameter int ACC_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
  output logic       busy,
  output logic       done,
  output logic       mac_clr,
  output logic       mac_en,
  output logic [1:0] k_idx,
  output logic [3:0] a_addr,
  output logic [3:0] b_addr,
  output logic       wr_en,
  output logic [3:0] wr_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_MAC, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  localparam logic [1:0] DRAIN_LAST = (ACC_LAT > 0) ? 2'(ACC_LAT - 1) : 2'd0;

  state_t     state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic [1:0] k_q, k_d;
  logic [1:0] drain_q, drain_d;
  logic [3:0] wr_addr_q, wr_addr_d;

  // 3*x + y without a multiplier
  function automatic logic [3:0] idx3(input logic [1:0] x, input logic [1:0] y);
    return {1'b0, x, 1'b0} + {2'b00, x} + {2'b00, y};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      k_q       <= 2'd0;
      drain_q   <= 2'd0;
      wr_addr_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      k_q       <= k_d;
      drain_q   <= drain_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    k_d       = k_q;
    drain_d   = drain_q;
    wr_addr_d = wr_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          row_d   = 2'd0;
          col_d   = 2'd0;
          k_d     = 2'd0;
        end
      end
      S_CLEAR: begin
        state_d = S_MAC;
        k_d     = 2'd0;
      end
      S_MAC: begin
        if (!stall) begin
          if (k_q == 2'd2) begin
            k_d     = 2'd0;
            drain_d = 2'd0;
            state_d = (ACC_LAT == 0) ? S_WRITE : S_DRAIN;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          if (drain_q == DRAIN_LAST) begin
            drain_d = 2'd0;
            state_d = S_WRITE;
          end else begin
            drain_d = drain_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        if (row_q == 2'd2 && col_q == 2'd2) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CLEAR;
          if (col_q == 2'd2) begin
            col_d = 2'd0;
            row_d = row_q + 2'd1;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        row_d   = 2'd0;
        col_d   = 2'd0;
        k_d     = 2'd0;
      end
      default: state_d = S_IDLE;
    endcase
    // wr_addr is captured on entry to WRITE and then held, so the decoder
    // only ever sees an index that was really written
    if (state_d == S_WRITE && state_q != S_WRITE)
      wr_addr_d = idx3(row_q, col_q);
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    mac_clr = (state_q == S_CLEAR);
    mac_en  = (state_q == S_MAC) && !stall;
    wr_en   = (state_q == S_WRITE);
    k_idx   = k_q;
    a_addr  = idx3(row_q, k_q);
    b_addr  = idx3(k_q, col_q);
    wr_addr = wr_addr_q;
  end

endmodule

// File: tb/tb_mm3x3_sequencer.sv
// Bench for mm3x3_sequencer: two instances (ACC_LAT=1 and 0) driven from
// per-cycle input tables and compared cycle by cycle to a schedule model.
module tb_mm3x3_sequencer;

  localparam int NC = 140;

  typedef struct packed {
    logic       chk, achk, busy, done, clr, en, wr;
    logic [1:0] k;
    logic [3:0] a, b, wa;
  } rec_t;

  logic clk;
  logic rst_i [2];
  logic start_i [2];
  logic stall_i [2];
  logic busy_o [2];
  logic done_o [2];
  logic clr_o [2];
  logic en_o [2];
  logic wr_o [2];
  logic [1:0] k_o [2];
  logic [3:0] a_o [2];
  logic [3:0] b_o [2];
  logic [3:0] wa_o [2];

  bit   sa [2][NC];
  bit   st [2][NC];
  bit   rs [2][NC];
  rec_t ex [2][NC];
  rec_t q[$];

  int total = 0;
  int bad = 0;
  int done_cnt [2];
  int first_done [2];
  int second_done [2];
  int first_wr [2];
  int wr_cnt [2];
  int en_cnt [2];

  mm3x3_sequencer #(.ACC_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst_i[0]), .start(start_i[0]), .stall(stall_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .mac_clr(clr_o[0]), .mac_en(en_o[0]),
    .k_idx(k_o[0]), .a_addr(a_o[0]), .b_addr(b_o[0]), .wr_en(wr_o[0]),
    .wr_addr(wa_o[0])
  );

  mm3x3_sequencer #(.ACC_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst_i[1]), .start(start_i[1]), .stall(stall_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .mac_clr(clr_o[1]), .mac_en(en_o[1]),
    .k_idx(k_o[1]), .a_addr(a_o[1]), .b_addr(b_o[1]), .wr_en(wr_o[1]),
    .wr_addr(wa_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int d, input int c,
                     input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d cyc%0d observed=%0h expected=%0h", tag, d, c, obs, exp);
    end
  endtask

  function automatic bit stl(input int d, input int c);
    return (c < NC) ? st[d][c] : 1'b0;
  endfunction

  // One uninterrupted run starting with its CLEAR cycle at c0
  task automatic build_run(input int d, input int lat, input int c0, input logic [3:0] wa_in);
    int c;
    int n;
    rec_t r;
    logic [3:0] wa;
    q.delete();
    c = c0;
    wa = wa_in;
    for (int e = 0; e < 9; e++) begin
      int row, col;
      row = e / 3;
      col = e % 3;
      r = '0; r.chk = 1; r.busy = 1; r.clr = 1; r.wa = wa;
      q.push_back(r); c++;
      for (int k = 0; k < 3; k++) begin
        r = '0; r.chk = 1; r.busy = 1; r.achk = 1; r.wa = wa;
        r.k = 2'(k); r.a = 4'(3 * row + k); r.b = 4'(3 * k + col);
        while (stl(d, c)) begin q.push_back(r); c++; end
        r.en = 1;
        q.push_back(r); c++;
      end
      n = 0;
      while (n < lat) begin
        r = '0; r.chk = 1; r.busy = 1; r.wa = wa;
        if (!stl(d, c)) n++;
        q.push_back(r); c++;
      end
      wa = 4'(e);
      r = '0; r.chk = 1; r.busy = 1; r.wr = 1; r.wa = wa;
      q.push_back(r); c++;
    end
    r = '0; r.chk = 1; r.busy = 1; r.done = 1; r.wa = wa;
    q.push_back(r);
  endtask

  // Expected outputs per cycle, given the start/stall/reset tables
  task automatic model(input int d, input int lat);
    int c;
    logic [3:0] wa;
    bit after;
    rec_t r;
    c = 0;
    wa = 4'd0;
    after = 0;
    while (c < NC) begin
      r = '0; r.chk = (c != 0); r.achk = after; r.wa = wa;
      ex[d][c] = r;
      after = 0;
      if (rs[d][c]) begin wa = 4'd0; after = 1; c++; continue; end
      if (!sa[d][c]) begin c++; continue; end
      c++;
      build_run(d, lat, c, wa);
      foreach (q[i]) begin
        if (c >= NC) break;
        ex[d][c] = q[i];
        wa = q[i].wa;
        if (rs[d][c]) begin wa = 4'd0; after = 1; c++; break; end
        c++;
      end
    end
  endtask

  task automatic clr_tables();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NC; c++) begin
        sa[d][c] = 0; st[d][c] = 0; rs[d][c] = (c == 0);
      end
  endtask

  task automatic run_scn();
    model(0, 1);
    model(1, 0);
    for (int d = 0; d < 2; d++) begin
      done_cnt[d] = 0; first_done[d] = -1; second_done[d] = -1;
      first_wr[d] = -1; wr_cnt[d] = 0; en_cnt[d] = 0;
    end
    for (int c = 0; c < NC; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        rst_i[d] = rs[d][c]; start_i[d] = sa[d][c]; stall_i[d] = st[d][c];
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (c > 0) begin
          if (done_o[d] === 1'b1) begin
            done_cnt[d]++;
            if (first_done[d] < 0) first_done[d] = c;
            else if (second_done[d] < 0) second_done[d] = c;
          end
          if (wr_o[d] === 1'b1) begin
            wr_cnt[d]++;
            if (first_wr[d] < 0) first_wr[d] = c;
          end
          if (en_o[d] === 1'b1) en_cnt[d]++;
        end
        if (ex[d][c].chk) begin
          chk("busy", d, c, 32'(busy_o[d]), 32'(ex[d][c].busy));
          chk("done", d, c, 32'(done_o[d]), 32'(ex[d][c].done));
          chk("mac_clr", d, c, 32'(clr_o[d]), 32'(ex[d][c].clr));
          chk("mac_en", d, c, 32'(en_o[d]), 32'(ex[d][c].en));
          chk("wr_en", d, c, 32'(wr_o[d]), 32'(ex[d][c].wr));
          chk("wr_addr", d, c, 32'(wa_o[d]), 32'(ex[d][c].wa));
          if (ex[d][c].achk) begin
            chk("k_idx", d, c, 32'(k_o[d]), 32'(ex[d][c].k));
            chk("a_addr", d, c, 32'(a_o[d]), 32'(ex[d][c].a));
            chk("b_addr", d, c, 32'(b_o[d]), 32'(ex[d][c].b));
          end
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_i[d] = 1'b1; start_i[d] = 1'b0; stall_i[d] = 1'b0;
    end

    // single run, start accepted at the edge ending cycle 1
    clr_tables();
    for (int d = 0; d < 2; d++) sa[d][1] = 1;
    run_scn();
    for (int d = 0; d < 2; d++) begin
      chk("single_done_cyc", d, -1, 32'(first_done[d]), (d == 0) ? 32'd56 : 32'd47);
      chk("single_done_cnt", d, -1, 32'(done_cnt[d]), 32'd1);
      chk("single_wr_cnt", d, -1, 32'(wr_cnt[d]), 32'd9);
      chk("single_mac_cnt", d, -1, 32'(en_cnt[d]), 32'd27);
    end

    // two stall cycles on the second MAC of element 0
    clr_tables();
    for (int d = 0; d < 2; d++) begin
      sa[d][1] = 1; st[d][4] = 1; st[d][5] = 1;
    end
    run_scn();
    for (int d = 0; d < 2; d++) begin
      chk("stall_first_wr", d, -1, 32'(first_wr[d]), (d == 0) ? 32'd9 : 32'd8);
      chk("stall_done_cyc", d, -1, 32'(first_done[d]), (d == 0) ? 32'd58 : 32'd49);
      chk("stall_mac_cnt", d, -1, 32'(en_cnt[d]), 32'd27);
    end

    // start pulse while busy is ignored
    clr_tables();
    for (int d = 0; d < 2; d++) begin sa[d][1] = 1; sa[d][11] = 1; end
    run_scn();
    for (int d = 0; d < 2; d++) begin
      chk("busy_start_done_cnt", d, -1, 32'(done_cnt[d]), 32'd1);
      chk("busy_start_wr_cnt", d, -1, 32'(wr_cnt[d]), 32'd9);
      chk("busy_start_done_cyc", d, -1, 32'(first_done[d]), (d == 0) ? 32'd56 : 32'd47);
    end

    // reset during the WRITE of element 3, then a fresh start
    clr_tables();
    for (int d = 0; d < 2; d++) begin sa[d][1] = 1; sa[d][30] = 1; end
    rs[0][25] = 1;
    rs[1][21] = 1;
    run_scn();
    for (int d = 0; d < 2; d++) begin
      chk("rst_done_cnt", d, -1, 32'(done_cnt[d]), 32'd1);
      chk("rst_done_cyc", d, -1, 32'(first_done[d]), (d == 0) ? 32'd85 : 32'd76);
    end

    // start held high: back-to-back runs
    clr_tables();
    for (int d = 0; d < 2; d++)
      for (int c = 1; c < NC; c++) sa[d][c] = 1;
    run_scn();
    for (int d = 0; d < 2; d++) begin
      chk("b2b_done1", d, -1, 32'(first_done[d]), (d == 0) ? 32'd56 : 32'd47);
      chk("b2b_done2", d, -1, 32'(second_done[d]), (d == 0) ? 32'd112 : 32'd94);
    end

    // random stalls, stray starts and occasional resets
    for (int s = 0; s < 5; s++) begin
      clr_tables();
      for (int d = 0; d < 2; d++) begin
        sa[d][1] = 1;
        for (int c = 1; c < NC; c++) begin
          st[d][c] = ($urandom_range(3) == 0);
          if ($urandom_range(19) == 0) sa[d][c] = 1;
          if (c > 2 && $urandom_range(119) == 0) rs[d][c] = 1;
        end
      end
      run_scn();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mm3x3_sequencer.md
# mm3x3_sequencer

Sequencing controller for the 3x3 matrix-multiply datapath. It computes C = A x B one output element at a time, in row-major order. For each element it clears the accumulator, issues three MAC steps with operand addresses, waits out the accumulator latency, and then emits a write strobe. The write index and enable drive the 0..8 one-hot write decoder (address A, enable En) that selects which C register captures the result.

## Interface
Parameters:
- ACC_LAT, 1: drain cycles between the last MAC and the write strobe; legal range 0..3.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request one full 3x3 multiply; sampled only in IDLE
- stall  in  1  operand-not-ready; freezes MAC and DRAIN progress
- busy  out  1  high from the first CLEAR cycle through the DONE cycle
- done  out  1  one-cycle pulse when all 9 elements are written
- mac_clr  out  1  accumulator clear, one cycle per element
- mac_en  out  1  accumulate A[a_addr]*B[b_addr] this cycle
- k_idx  out  2  inner-product step 0..2
- a_addr  out  4  A element index = 3*row + k
- b_addr  out  4  B element index = 3*k + col
- wr_en  out  1  write strobe; connects to decoder En
- wr_addr  out  4  C element index 0..8 = 3*row + col; connects to decoder A

## Operation
- Moore FSM with states IDLE, CLEAR, MAC, DRAIN, WRITE, DONE. Internal counters: row 0..2, col 0..2, k 0..2, drain 0..ACC_LAT-1. Row and col are kept as wrapping counters; no divider.
- **IDLE**: all strobes low. When start=1, go to CLEAR with row=col=k=0.
- **CLEAR**: mac_clr=1 and k=0. Go to MAC next cycle. stall is ignored.
- **MAC**:
  - stall=0: mac_en=1 and addresses are valid. k increments; after k=2, go to DRAIN (or straight to WRITE if ACC_LAT=0).
  - stall=1: mac_en=0, k holds, a_addr and b_addr hold their values.
- **DRAIN**: counts ACC_LAT non-stalled cycles, then goes to WRITE.
- **WRITE**: wr_en=1 and wr_addr=3*row+col for one cycle. stall is ignored.
  - If wr_addr=8, go to DONE.
  - Otherwise col increments; on wrap 2->0, row increments. Then go to CLEAR.
- **DONE**: done=1 and busy=1 for one cycle, then go to IDLE. Back-to-back operation: start is sampled again in IDLE the following cycle.
- start while busy is ignored; it is not queued.
- Outside MAC, mac_en=0. Outside WRITE, wr_en=0 and wr_addr holds its last value.
- wr_addr never exceeds 8. Codes 9..15 are never produced, so the decoder never sees an unmapped index.
- **Reset values**: state IDLE; busy, done, mac_clr, mac_en, wr_en = 0; k_idx, a_addr, b_addr, wr_addr = 0; all counters 0.
- Reset mid-operation aborts immediately. The next cycle is IDLE, and no done or wr_en is emitted for the partial result.

## Timing
- Start is accepted at edge t0. CLEAR for element 0 occupies cycle t0+1.
- Per element, with no stalls: 1 CLEAR + 3 MAC + ACC_LAT DRAIN + 1 WRITE = 5+ACC_LAT cycles.
- Each stalled cycle in MAC or DRAIN adds exactly one cycle.
- DONE occurs at cycle t0+1+9*(5+ACC_LAT). With ACC_LAT=1 that is t0+55.
- busy rises at t0+1 and falls the cycle after DONE.
- For element e (cycle offsets from its CLEAR cycle, no stalls):
  - mac_en high at offsets +1..+3 with k=0,1,2.
  - wr_en high at offset +4+ACC_LAT.
- All outputs are registered-state decodes. There are no combinational paths from start or stall to wr_en.

## Test plan
- **Single run**: ACC_LAT=1, pulse start.
  - wr_en pulses with wr_addr 0,1,...,8 at t0+1+6e+5.
  - done at t0+55.
  - Exactly 27 mac_en cycles.
- **Address check**: for element 5 (row 1, col 2), the MAC cycles show (a_addr, b_addr) = (3,2), (4,5), (5,8).
- **Stall**:
  - stall=1 for 2 cycles at the second MAC of element 0: k_idx holds at 1, mac_en=0 for those cycles, and wr_en for element 0 is delayed by 2 cycles.
  - Total run time is t0+57.
- **Start while busy**: pulse start at t0+10. No restart and no extra done; exactly 9 wr_en pulses.
- **Reset mid-run**:
  - Assert rst during the WRITE of element 3: the next cycle is IDLE with all outputs 0, and done is never seen.
  - A subsequent start produces a full 9-write sequence from wr_addr 0.
- **ACC_LAT=0 back-to-back**:
  - done at t0+46.
  - Start held high through DONE: the second run's CLEAR begins 2 cycles after done.
